ddc_i2c_master: RTL and testbench

Byte-level I2C/DDC master driving the open-drain SCL/SDA pair of one QSFP-HDMI port, shared by the EDID reader and the NB7NQ621M redriver configuration sequencer. It sits directly upstream of the pad IOBUFs. `scl_output`/`sda_output` drive both the IOBUF data input and its tristate enable, so 1 releases the line and 0 pulls it low. Callers issue START/WRITE/READ/STOP commands through a valid/ready handshake and receive one response per command.

---
 rtl/ddc_i2c_master.sv | 204 ++++++++++++++++++++
 tb/tb_ddc_i2c_master.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddc_i2c_master.sv
`default_nettype none
// ============================================================================
// Module   : ddc_i2c_master
// Purpose  : Byte-level I2C/DDC master (START/WRITE/READ/STOP) for one
//            QSFP-HDMI port. Optional slave clock stretching is enabled by
//            defining DDC_I2C_CLOCK_STRETCH_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ddc_i2c_master #(
    parameter int CLOCK_FREQUENCY = 200_000_000,
    parameter int I2C_FREQUENCY   = 100_000
) (
    input  logic       system_clock,
    input  logic       system_reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd,
    input  logic [7:0] cmd_data,
    input  logic       cmd_ack,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_nack,
    output logic       busy,
    input  logic       scl_input,
    input  logic       sda_input,
    output logic       scl_output,
    output logic       sda_output
);

    localparam int QUARTER = CLOCK_FREQUENCY / (4 * I2C_FREQUENCY);
    localparam int QW      = $clog2(QUARTER);

    localparam logic [QW-1:0] c_q_last    = QW'(QUARTER - 1);
    localparam logic [1:0]    c_cmd_start = 2'd0;
    localparam logic [1:0]    c_cmd_write = 2'd1;
    localparam logic [1:0]    c_cmd_read  = 2'd2;

`ifdef DDC_I2C_CLOCK_STRETCH_EN
    localparam logic c_stretch_en = 1'b1;
`else
    localparam logic c_stretch_en = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_BIT   = 3'd2,
        S_STOP  = 3'd3,
        S_DONE  = 3'd4
    } t_state;

    t_state        r_state, w_state_next;
    logic [QW-1:0] r_qcnt, w_qcnt_next;
    logic [1:0]    r_phase, w_phase_next;
    logic [3:0]    r_bit_cnt, w_bit_next;
    logic [8:0]    r_shift, w_shift_next;
    logic [1:0]    r_cmd, w_cmd_next;
    logic          r_scl, w_scl_next;
    logic          r_sda, w_sda_next;
    logic [7:0]    r_rsp_data;
    logic          r_rsp_nack;
    logic          r_scl_meta, r_scl_sync;
    logic          r_sda_meta, r_sda_sync;
    logic          w_active;
    logic          w_hold;
    logic          w_tick;
    logic          w_rsp_load;

    always_ff @(posedge system_clock or posedge system_reset) begin
        if (system_reset) begin
            r_scl_meta <= 1'b1;
            r_scl_sync <= 1'b1;
            r_sda_meta <= 1'b1;
            r_sda_sync <= 1'b1;
        end else begin
            r_scl_meta <= scl_input;
            r_scl_sync <= r_scl_meta;
            r_sda_meta <= sda_input;
            r_sda_sync <= r_sda_meta;
        end
    end

    assign w_active = (r_state == S_START) || (r_state == S_BIT) || (r_state == S_STOP);
    // A slave holding SCL low while we release it freezes the quarter timer.
    assign w_hold   = c_stretch_en && w_active &&
                      ((r_phase == 2'd1) || (r_phase == 2'd2)) && !r_scl_sync;
    assign w_rsp_load = (r_state != S_DONE) && (w_state_next == S_DONE);

    always_comb begin
        w_state_next = r_state;
        w_qcnt_next  = r_qcnt;
        w_phase_next = r_phase;
        w_bit_next   = r_bit_cnt;
        w_shift_next = r_shift;
        w_cmd_next   = r_cmd;
        w_scl_next   = r_scl;
        w_sda_next   = r_sda;
        w_tick       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_tick       = 1'b1;
                    w_qcnt_next  = '0;
                    w_phase_next = 2'd0;
                    w_bit_next   = 4'd0;
                    w_cmd_next   = cmd;
                    case (cmd)
                        c_cmd_start: w_state_next = S_START;
                        c_cmd_write: begin
                            w_state_next = S_BIT;
                            w_shift_next = {cmd_data, 1'b1};
                        end
                        c_cmd_read: begin
                            w_state_next = S_BIT;
                            w_shift_next = {8'hFF, cmd_ack};
                        end
                        default: w_state_next = S_STOP;
                    endcase
                end
            end
            S_START, S_BIT, S_STOP: begin
                if (!w_hold) begin
                    if (r_qcnt == c_q_last) begin
                        w_tick       = 1'b1;
                        w_qcnt_next  = '0;
                        w_phase_next = r_phase + 2'd1;
                        if ((r_state == S_BIT) && (r_phase == 2'd2))
                            w_shift_next = {r_shift[7:0], r_sda_sync};
                        if (r_phase == 2'd3) begin
                            if ((r_state == S_BIT) && (r_bit_cnt != 4'd8))
                                w_bit_next = r_bit_cnt + 4'd1;
                            else
                                w_state_next = S_DONE;
                        end
                    end else begin
                        w_qcnt_next = r_qcnt + QW'(1);
                    end
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase

        // Lines only move when a new quarter begins; DONE/IDLE keep the bus as left.
        if (w_tick) begin
            case (w_state_next)
                S_START: begin
                    w_sda_next = ~w_phase_next[1];
                    w_scl_next = w_phase_next[0] ^ w_phase_next[1];
                end
                S_BIT: begin
                    w_scl_next = w_phase_next[0] ^ w_phase_next[1];
                    if (w_phase_next == 2'd0)
                        w_sda_next = w_shift_next[8];
                end
                S_STOP: begin
                    w_scl_next = (w_phase_next != 2'd0);
                    w_sda_next = (w_phase_next == 2'd3);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge system_clock or posedge system_reset) begin
        if (system_reset) begin
            r_state    <= S_IDLE;
            r_qcnt     <= '0;
            r_phase    <= 2'd0;
            r_bit_cnt  <= 4'd0;
            r_shift    <= '1;
            r_cmd      <= c_cmd_start;
            r_scl      <= 1'b1;
            r_sda      <= 1'b1;
            r_rsp_data <= 8'h00;
            r_rsp_nack <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_qcnt    <= w_qcnt_next;
            r_phase   <= w_phase_next;
            r_bit_cnt <= w_bit_next;
            r_shift   <= w_shift_next;
            r_cmd     <= w_cmd_next;
            r_scl     <= w_scl_next;
            r_sda     <= w_sda_next;
            if (w_rsp_load) begin
                r_rsp_nack <= (r_cmd == c_cmd_write) & r_shift[0];
                if (r_cmd == c_cmd_read)
                    r_rsp_data <= r_shift[8:1];
            end
        end
    end

    assign cmd_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign rsp_valid  = (r_state == S_DONE);
    assign rsp_data   = r_rsp_data;
    assign rsp_nack   = r_rsp_nack;
    assign scl_output = r_scl;
    assign sda_output = r_sda;

endmodule
`default_nettype wire

// File: tb/tb_ddc_i2c_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddc_i2c_master
// Purpose  : Directed self-checking bench for ddc_i2c_master with an
//            open-drain bus model and a simple ACK/READ/stretching slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddc_i2c_master;

    localparam int CLK_HZ = 1_600_000;
    localparam int I2C_HZ = 100_000;
    localparam int Q      = 4;
    localparam int c_ph   = 4 * Q;
`ifdef DDC_I2C_CLOCK_STRETCH_EN
    localparam int c_lag     = 2;
    localparam int c_stretch = 1000;
`else
    localparam int c_lag     = 0;
    localparam int c_stretch = 0;
`endif
    localparam int c_lat_ss = c_ph + 1 + c_lag;
    localparam int c_lat_rw = 9 * c_ph + 1 + 9 * c_lag;

    logic       system_clock = 1'b0;
    logic       system_reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd = 2'd0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_ack = 1'b1;
    logic       cmd_ready, rsp_valid, rsp_nack, busy, scl_output, sda_output;
    logic [7:0] rsp_data;
    logic       slave_scl = 1'b1;
    logic       slave_sda = 1'b1;
    logic       scl_pad, sda_pad;

    assign scl_pad = scl_output & slave_scl;
    assign sda_pad = sda_output & slave_sda;

    ddc_i2c_master #(.CLOCK_FREQUENCY(CLK_HZ), .I2C_FREQUENCY(I2C_HZ)) dut (
        .system_clock(system_clock), .system_reset(system_reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
        .cmd_data(cmd_data), .cmd_ack(cmd_ack),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_nack(rsp_nack),
        .busy(busy), .scl_input(scl_pad), .sda_input(sda_pad),
        .scl_output(scl_output), .sda_output(sda_output)
    );

    always #5 system_clock = ~system_clock;

    int n_vec = 0;
    int n_err = 0;

    // Bus observer and slave: 0 = silent, 1 = ACK a write, 2 = return slave_byte.
    int          slave_mode = 0;
    logic [7:0]  slave_byte = 8'h00;
    bit          slave_stretch = 1'b0;
    int          arm_seq = 0, seen_seq = 0, falls = 0, stretch_left = 0;
    bit          stretch_done = 1'b0;
    int          rise_cnt = 0, start_cnt = 0, stop_cnt = 0, low_rise_cnt = 0, rsp_cnt = 0;
    logic [31:0] bit_log = '1;
    logic        scl_prev = 1'b1, sda_prev = 1'b1, scl_out_prev = 1'b1;

    always @(negedge system_clock) begin : bus_model
        logic scl_now, sda_now;
        if (arm_seq != seen_seq) begin
            seen_seq     = arm_seq;
            falls        = 0;
            stretch_done = 1'b0;
        end
        if (stretch_left > 0) begin
            stretch_left = stretch_left - 1;
            if (stretch_left == 0) slave_scl = 1'b1;
        end else if (slave_stretch && !stretch_done && falls == 3 && scl_output && !scl_out_prev) begin
            slave_scl    = 1'b0;
            stretch_left = 1000;
            stretch_done = 1'b1;
        end
        scl_out_prev = scl_output;
        scl_now = scl_output & slave_scl;
        if (scl_prev && !scl_now) falls = falls + 1;
        case (slave_mode)
            1:       slave_sda = (falls == 8) ? 1'b0 : 1'b1;
            2:       slave_sda = (falls < 8) ? slave_byte[7 - falls] : 1'b1;
            default: slave_sda = 1'b1;
        endcase
        sda_now = sda_output & slave_sda;
        if (!scl_prev && scl_now) begin
            rise_cnt = rise_cnt + 1;
            bit_log  = {bit_log[30:0], sda_now};
        end
        if (scl_prev && scl_now && sda_prev && !sda_now) start_cnt = start_cnt + 1;
        if (scl_prev && scl_now && !sda_prev && sda_now) stop_cnt = stop_cnt + 1;
        if (!scl_prev && !scl_now && !sda_prev && sda_now) low_rise_cnt = low_rise_cnt + 1;
        if (rsp_valid) rsp_cnt = rsp_cnt + 1;
        scl_prev = scl_now;
        sda_prev = sda_now;
    end

    task automatic arm(input int mode, input logic [7:0] b, input bit st);
        slave_mode    = mode;
        slave_byte    = b;
        slave_stretch = st;
        arm_seq       = arm_seq + 1;
    endtask

    // Issues one command; lat = cycles from accept to rsp_valid, -1 on timeout.
    task automatic do_cmd(input logic [1:0] c, input logic [7:0] d, input logic a, output int lat);
        int guard = 0;
        while (!cmd_ready && guard < 5000) begin
            @(negedge system_clock);
            guard++;
        end
        cmd_valid = 1'b1;
        cmd       = c;
        cmd_data  = d;
        cmd_ack   = a;
        lat       = -1;
        for (int i = 1; i <= 3000; i++) begin
            @(negedge system_clock);
            cmd_valid = 1'b0;
            if (rsp_valid) begin
                lat = i;
                break;
            end
        end
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        system_reset = 1'b1;
        repeat (3) @(negedge system_clock);
        system_reset = 1'b0;
        @(negedge system_clock);
        n_vec++; if (scl_output !== 1'b1) begin n_err++; $display("FAIL reset_scl: got %b expected 1", scl_output); end
        n_vec++; if (sda_output !== 1'b1) begin n_err++; $display("FAIL reset_sda: got %b expected 1", sda_output); end
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        n_vec++; if (rsp_data !== 8'h00) begin n_err++; $display("FAIL reset_rsp_data: got %h expected 00", rsp_data); end
        n_vec++; if (rsp_nack !== 1'b0) begin n_err++; $display("FAIL reset_rsp_nack: got %b expected 0", rsp_nack); end
    endtask

    task automatic test_write_ack;
        int lat, r0, p0;
        p0 = stop_cnt;
        arm(0, 8'h00, 1'b0);
        do_cmd(2'd0, 8'h00, 1'b1, lat);
        n_vec++; if (lat !== c_lat_ss) begin n_err++; $display("FAIL start_latency: got %0d expected %0d", lat, c_lat_ss); end
        arm(1, 8'h00, 1'b0);
        r0 = rise_cnt;
        do_cmd(2'd1, 8'hA0, 1'b1, lat);
        n_vec++; if (lat !== c_lat_rw) begin n_err++; $display("FAIL write_latency: got %0d expected %0d", lat, c_lat_rw); end
        n_vec++; if (rise_cnt - r0 !== 9) begin n_err++; $display("FAIL write_scl_rises: got %0d expected 9", rise_cnt - r0); end
        n_vec++; if (bit_log[8:1] !== 8'hA0) begin n_err++; $display("FAIL write_sda_bits: got %h expected a0", bit_log[8:1]); end
        n_vec++; if (bit_log[0] !== 1'b0) begin n_err++; $display("FAIL write_ack_bit: got %b expected 0", bit_log[0]); end
        n_vec++; if (rsp_nack !== 1'b0) begin n_err++; $display("FAIL write_rsp_nack: got %b expected 0", rsp_nack); end
        arm(0, 8'h00, 1'b0);
        do_cmd(2'd3, 8'h00, 1'b1, lat);
        n_vec++; if (lat !== c_lat_ss) begin n_err++; $display("FAIL stop_latency: got %0d expected %0d", lat, c_lat_ss); end
        n_vec++; if ({scl_output, sda_output} !== 2'b11) begin n_err++; $display("FAIL stop_lines: got %b expected 11", {scl_output, sda_output}); end
        n_vec++; if (stop_cnt - p0 !== 1) begin n_err++; $display("FAIL stop_condition: got %0d expected 1", stop_cnt - p0); end
    endtask

    task automatic test_write_nack;
        int lat, r0;
        arm(0, 8'h00, 1'b0);
        r0 = rise_cnt;
        do_cmd(2'd1, 8'h74, 1'b1, lat);
        n_vec++; if (lat !== c_lat_rw) begin n_err++; $display("FAIL nack_latency: got %0d expected %0d", lat, c_lat_rw); end
        n_vec++; if (rise_cnt - r0 !== 9) begin n_err++; $display("FAIL nack_scl_rises: got %0d expected 9", rise_cnt - r0); end
        n_vec++; if (bit_log[8:1] !== 8'h74) begin n_err++; $display("FAIL nack_sda_bits: got %h expected 74", bit_log[8:1]); end
        n_vec++; if (rsp_nack !== 1'b1) begin n_err++; $display("FAIL nack_rsp_nack: got %b expected 1", rsp_nack); end
        do_cmd(2'd3, 8'h00, 1'b1, lat);
    endtask

    task automatic test_read;
        int lat;
        arm(0, 8'h00, 1'b0);
        do_cmd(2'd0, 8'h00, 1'b1, lat);
        arm(2, 8'hA5, 1'b0);
        do_cmd(2'd2, 8'h00, 1'b1, lat);
        n_vec++; if (lat !== c_lat_rw) begin n_err++; $display("FAIL read_latency: got %0d expected %0d", lat, c_lat_rw); end
        n_vec++; if (rsp_data !== 8'hA5) begin n_err++; $display("FAIL read_rsp_data: got %h expected a5", rsp_data); end
        n_vec++; if (rsp_nack !== 1'b0) begin n_err++; $display("FAIL read_rsp_nack: got %b expected 0", rsp_nack); end
        n_vec++; if (bit_log[0] !== 1'b1) begin n_err++; $display("FAIL read_ninth_released: got %b expected 1", bit_log[0]); end
        arm(0, 8'h00, 1'b0);
        do_cmd(2'd3, 8'h00, 1'b1, lat);
        n_vec++; if (rsp_data !== 8'hA5) begin n_err++; $display("FAIL read_data_hold: got %h expected a5", rsp_data); end
    endtask

    task automatic test_repeated_start;
        int lat, s0, p0, l0;
        s0 = start_cnt;
        p0 = stop_cnt;
        arm(0, 8'h00, 1'b0);
        do_cmd(2'd0, 8'h00, 1'b1, lat);
        l0 = low_rise_cnt;
        arm(1, 8'h00, 1'b0);
        do_cmd(2'd1, 8'h3C, 1'b1, lat);
        arm(0, 8'h00, 1'b0);
        do_cmd(2'd0, 8'h00, 1'b1, lat);
        n_vec++; if (start_cnt - s0 !== 2) begin n_err++; $display("FAIL rstart_starts: got %0d expected 2", start_cnt - s0); end
        n_vec++; if (stop_cnt - p0 !== 0) begin n_err++; $display("FAIL rstart_no_stop: got %0d expected 0", stop_cnt - p0); end
        n_vec++; if ((low_rise_cnt > l0) !== 1'b1) begin n_err++; $display("FAIL rstart_low_rise: got %0d expected >%0d", low_rise_cnt, l0); end
        n_vec++; if ({scl_output, sda_output} !== 2'b00) begin n_err++; $display("FAIL rstart_lines: got %b expected 00", {scl_output, sda_output}); end
        do_cmd(2'd3, 8'h00, 1'b1, lat);
    endtask

    task automatic test_back_to_back;
        int lat;
        arm(0, 8'h00, 1'b0);
        do_cmd(2'd0, 8'h00, 1'b1, lat);
        n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_in_done: got %b expected 0", cmd_ready); end
        @(negedge system_clock);
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_after: got %b expected 1", cmd_ready); end
        do_cmd(2'd3, 8'h00, 1'b1, lat);
        n_vec++; if (lat !== c_lat_ss) begin n_err++; $display("FAIL b2b_stop_latency: got %0d expected %0d", lat, c_lat_ss); end
    endtask

    task automatic test_stretch;
        int lat;
        arm(0, 8'h00, 1'b0);
        do_cmd(2'd0, 8'h00, 1'b1, lat);
        arm((c_stretch > 0) ? 1 : 0, 8'h00, 1'b1);
        do_cmd(2'd1, 8'h5A, 1'b1, lat);
        n_vec++; if (lat !== c_lat_rw + c_stretch) begin n_err++; $display("FAIL stretch_latency: got %0d expected %0d", lat, c_lat_rw + c_stretch); end
        n_vec++; if (rsp_nack !== ((c_stretch > 0) ? 1'b0 : 1'b1)) begin n_err++; $display("FAIL stretch_rsp_nack: got %b", rsp_nack); end
`ifdef DDC_I2C_CLOCK_STRETCH_EN
        n_vec++; if (bit_log[8:1] !== 8'h5A) begin n_err++; $display("FAIL stretch_data: got %h expected 5a", bit_log[8:1]); end
`endif
        repeat (1100) @(negedge system_clock);
        arm(0, 8'h00, 1'b0);
        do_cmd(2'd3, 8'h00, 1'b1, lat);
    endtask

    task automatic test_reset_mid;
        int lat, r0, guard;
        guard = 0;
        arm(0, 8'h00, 1'b0);
        while (!cmd_ready && guard < 5000) begin @(negedge system_clock); guard++; end
        cmd_valid = 1'b1; cmd = 2'd1; cmd_data = 8'h00;
        @(negedge system_clock);
        cmd_valid = 1'b0;
        repeat (81 + 5 * c_lag - 1) @(negedge system_clock);
        n_vec++; if ({busy, scl_output, sda_output} !== 3'b100) begin n_err++; $display("FAIL mid_bit5_lines: got %b expected 100", {busy, scl_output, sda_output}); end
        r0 = rsp_cnt;
        system_reset = 1'b1;
        #1;
        n_vec++; if ({scl_output, sda_output} !== 2'b11) begin n_err++; $display("FAIL mid_reset_release: got %b expected 11", {scl_output, sda_output}); end
        @(negedge system_clock);
        system_reset = 1'b0;
        repeat (200) @(negedge system_clock);
        n_vec++; if (rsp_cnt !== r0) begin n_err++; $display("FAIL mid_no_rsp: got %0d expected %0d", rsp_cnt, r0); end
        n_vec++; if ({cmd_ready, busy} !== 2'b10) begin n_err++; $display("FAIL mid_ready_after: got %b expected 10", {cmd_ready, busy}); end
        do_cmd(2'd0, 8'h00, 1'b1, lat);
        n_vec++; if (lat !== c_lat_ss) begin n_err++; $display("FAIL recover_start: got %0d expected %0d", lat, c_lat_ss); end
        do_cmd(2'd3, 8'h00, 1'b1, lat);
        n_vec++; if ({scl_output, sda_output} !== 2'b11) begin n_err++; $display("FAIL recover_lines: got %b expected 11", {scl_output, sda_output}); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_write_ack;
        test_write_nack;
        test_read;
        test_repeated_start;
        test_back_to_back;
        test_stretch;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
